// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer and its forwarding matcher.
// Entry address width is fixed here; the top-level WIDTH parameter must equal SB_AW.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_PTRW  = $clog2(SB_DEPTH);
    localparam int SB_AW    = 12;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [31:0]      data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_sel_t;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match finder: rotated priority encoder over the live buffer entries.
// Purely combinational; the oldest entry sits at tail-DEPTH, the youngest at tail-1.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         i_valid,
    input  logic [DEPTH-1:0][AW-1:0] i_addr,
    input  logic [PTRW-1:0]          i_tail,
    input  logic [AW-1:0]            i_lookup,
    output logic                     o_hit,
    output logic [PTRW-1:0]          o_idx
);

    logic [DEPTH-1:0] w_match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign w_match[i] = i_valid[i] && (i_addr[i] == i_lookup);
    end

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_match[i_tail - PTRW'(k)]) begin
                o_hit = 1'b1;
                o_idx = i_tail - PTRW'(k);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer with commit/flush, drain to a single-port RAM and load forwarding.
// Load result 1 cycle after acceptance; stores stall when full, loads stall only when a full buffer must drain.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int WIDTH = SB_AW,
    parameter int DEPTH = SB_DEPTH,
    parameter int TAGW  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_st_valid,
    input  logic [WIDTH-1:0] i_st_addr,
    input  logic [31:0]      i_st_data,
    output logic             o_st_ready,
    input  logic             i_commit,
    input  logic             i_flush,
    input  logic             i_ld_valid,
    input  logic [WIDTH-1:0] i_ld_addr,
    input  logic [TAGW-1:0]  i_ld_tag,
    output logic             o_ld_ready,
    output logic             o_ld_valid,
    output logic [31:0]      o_ld_data,
    output logic [TAGW-1:0]  o_ld_tag,
    output logic             o_we,
    output logic [WIDTH-1:0] o_addr,
    output logic [31:0]      o_data,
    input  logic [31:0]      i_data
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    sb_entry_t              r_mem [DEPTH];
    logic [PTRW-1:0]        r_head, r_cmt, r_tail;
    logic [CW-1:0]          r_count, r_ncmt;
    logic                   r_ld_vld, r_ld_hit;
    logic [31:0]            r_ld_fwd;
    logic [TAGW-1:0]        r_ld_tag;

    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_addrs;
    logic                        w_hit;
    logic [PTRW-1:0]             w_hit_idx;
    logic                        w_full, w_has_cmt, w_has_unc;
    logic                        w_enq, w_commit, w_drain, w_ld;
    logic [PTRW-1:0]             w_cmt_nxt;
    logic [CW-1:0]               w_ncmt_nxt;
    arb_sel_t                    w_sel;

    // An entry is live when its distance from head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_live
        assign w_valid[i] = {1'b0, PTRW'(i) - r_head} < r_count;
        assign w_addrs[i] = r_mem[i].addr;
    end

    sb_match #(.DEPTH(DEPTH), .AW(WIDTH), .PTRW(PTRW)) u_match (
        .i_valid  (w_valid),
        .i_addr   (w_addrs),
        .i_tail   (r_tail),
        .i_lookup (i_ld_addr),
        .o_hit    (w_hit),
        .o_idx    (w_hit_idx)
    );

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_has_cmt = (r_ncmt != '0);
    assign w_has_unc = (r_count != r_ncmt);

    always_comb begin
        w_sel = ARB_IDLE;
        if (w_full && w_has_cmt)     w_sel = ARB_DRAIN;
        else if (i_ld_valid && rst_n) w_sel = ARB_LOAD;
        else if (w_has_cmt)          w_sel = ARB_DRAIN;
    end

    assign w_drain    = (w_sel == ARB_DRAIN);
    assign w_ld       = (w_sel == ARB_LOAD);
    assign o_ld_ready = w_ld;
    assign o_st_ready = ~w_full;

    // Forwarded loads leave the RAM port idle.
    assign o_we   = w_drain;
    assign o_addr = w_drain ? r_mem[r_head].addr :
                    (w_ld && !w_hit) ? i_ld_addr : '0;
    assign o_data = w_drain ? r_mem[r_head].data : '0;

    assign w_enq      = i_st_valid && !w_full && !i_flush;
    assign w_commit   = i_commit && w_has_unc;
    assign w_cmt_nxt  = r_cmt + PTRW'(w_commit);
    assign w_ncmt_nxt = r_ncmt + CW'(w_commit) - CW'(w_drain);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_cmt   <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ncmt  <= '0;
        end else begin
            r_head <= r_head + PTRW'(w_drain);
            r_cmt  <= w_cmt_nxt;
            r_ncmt <= w_ncmt_nxt;
            if (i_flush) begin
                r_tail  <= w_cmt_nxt;
                r_count <= w_ncmt_nxt;
            end else begin
                r_tail  <= r_tail + PTRW'(w_enq);
                r_count <= r_count + CW'(w_enq) - CW'(w_drain);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= '{addr: i_st_addr, data: i_st_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_vld <= 1'b0;
            r_ld_hit <= 1'b0;
            r_ld_fwd <= '0;
            r_ld_tag <= '0;
        end else begin
            r_ld_vld <= w_ld;
            if (w_ld) begin
                r_ld_tag <= i_ld_tag;
                r_ld_hit <= w_hit;
                r_ld_fwd <= r_mem[w_hit_idx].data;
            end
        end
    end

    assign o_ld_valid = r_ld_vld;
    assign o_ld_tag   = r_ld_tag;
    assign o_ld_data  = !r_ld_vld ? '0 : (r_ld_hit ? r_ld_fwd : i_data);

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run against a queue model.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_st_valid = 0, i_commit = 0, i_flush = 0, i_ld_valid = 0;
    logic [11:0] i_st_addr = '0, i_ld_addr = '0;
    logic [31:0] i_st_data = '0;
    logic [5:0]  i_ld_tag = '0;
    logic        o_st_ready, o_ld_ready, o_ld_valid, o_we;
    logic [31:0] o_ld_data, o_data;
    logic [5:0]  o_ld_tag;
    logic [11:0] o_addr;
    logic [31:0] i_data = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_buffer #(.WIDTH(12), .DEPTH(4), .TAGW(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_st_valid(i_st_valid), .i_st_addr(i_st_addr), .i_st_data(i_st_data), .o_st_ready(o_st_ready),
        .i_commit(i_commit), .i_flush(i_flush),
        .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr), .i_ld_tag(i_ld_tag), .o_ld_ready(o_ld_ready),
        .o_ld_valid(o_ld_valid), .o_ld_data(o_ld_data), .o_ld_tag(o_ld_tag),
        .o_we(o_we), .o_addr(o_addr), .o_data(o_data), .i_data(i_data)
    );

    // RAM model: unwritten words read back as a fixed address pattern.
    function automatic logic [31:0] pat(input logic [11:0] a);
        return {20'h5A5A5, a};
    endfunction

    logic [31:0] ram [4096];
    logic [4095:0] ram_wr = '0;
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (o_we) begin
            ram[o_addr] <= o_data;
            ram_wr[o_addr] <= 1'b1;
        end else if (bd_we) begin
            ram[bd_addr] <= bd_data;
            ram_wr[bd_addr] <= 1'b1;
        end
        i_data <= ram_wr[o_addr] ? ram[o_addr] : pat(o_addr);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        i_st_valid = 0; i_commit = 0; i_flush = 0; i_ld_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_in();
        #3;
        n_chk++; if (o_st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_st_ready got=%0b exp=1", o_st_ready); end
        n_chk++; if (o_ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready got=%0b exp=0", o_ld_ready); end
        n_chk++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%0b exp=0", o_we); end
        n_chk++; if (o_ld_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ld_valid got=%0b exp=0", o_ld_valid); end
        n_chk++; if ({o_addr, o_data, o_ld_data, o_ld_tag} !== '0) begin n_fail++;
            $display("FAIL rst_outs got addr=%h data=%h ld_data=%h tag=%h exp all 0", o_addr, o_data, o_ld_data, o_ld_tag); end
        tick(); rst_n = 1;
        tick();
        i_st_valid = 1; i_st_addr = 12'h030; i_st_data = 32'h3030_3030;
        tick();
        i_st_valid = 0; i_commit = 1;
        tick();
        i_commit = 0;
        #1;
        n_chk++; if (o_we !== 1'b1 || o_addr !== 12'h030) begin n_fail++; $display("FAIL rst_pre_drain got we=%0b addr=%h exp we=1 addr=030", o_we, o_addr); end
        i_ld_valid = 1; i_ld_addr = 12'h030; i_ld_tag = 6'd7; rst_n = 0;
        #1;
        n_chk++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drain_we got=%0b exp=0", o_we); end
        n_chk++; if (o_st_ready !== 1'b1 || o_ld_ready !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_ready got st=%0b ld=%0b exp st=1 ld=0", o_st_ready, o_ld_ready); end
        tick();
        n_chk++; if (o_ld_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_resp got=%0b exp=0", o_ld_valid); end
        i_ld_valid = 0; rst_n = 1;
        tick(); #1;
        n_chk++; if (o_ld_valid !== 1'b0 || o_we !== 1'b0) begin n_fail++;
            $display("FAIL rst_after got ld_valid=%0b we=%0b exp 0 0", o_ld_valid, o_we); end
    endtask

    task automatic test_drain();
        i_st_valid = 1; i_st_addr = 12'h010; i_st_data = 32'hDEADBEEF;
        tick();
        i_st_valid = 0; i_commit = 1; #1;
        n_chk++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL drain_early got we=%0b exp=0", o_we); end
        tick();
        i_commit = 0; #1;
        n_chk++; if (o_we !== 1'b1 || o_addr !== 12'h010 || o_data !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL drain_write got we=%0b addr=%h data=%h exp 1 010 deadbeef", o_we, o_addr, o_data); end
        tick(); #1;
        n_chk++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL drain_once got we=%0b exp=0", o_we); end
    endtask

    task automatic test_forward();
        i_st_valid = 1; i_st_addr = 12'h020; i_st_data = 32'h1111;
        tick();
        i_st_data = 32'h2222;
        tick();
        i_st_valid = 0; i_ld_valid = 1; i_ld_addr = 12'h020; i_ld_tag = 6'd5; #1;
        n_chk++; if (o_ld_ready !== 1'b1 || o_we !== 1'b0) begin n_fail++;
            $display("FAIL fwd_accept got ready=%0b we=%0b exp 1 0", o_ld_ready, o_we); end
        tick();
        i_ld_valid = 0; #1;
        n_chk++; if (o_ld_valid !== 1'b1 || o_ld_data !== 32'h2222 || o_ld_tag !== 6'd5 || o_we !== 1'b0) begin n_fail++;
            $display("FAIL fwd_result got v=%0b data=%h tag=%0d we=%0b exp 1 2222 5 0", o_ld_valid, o_ld_data, o_ld_tag, o_we); end
        tick(); #1;
        n_chk++; if (o_ld_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_pulse got=%0b exp=0", o_ld_valid); end
        i_flush = 1;
        tick();
        i_flush = 0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            i_st_valid = 1; i_st_addr = 12'h040 + 12'(i); i_st_data = 32'h4000 + i; #1;
            n_chk++; if (o_st_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d got ready=%0b exp=1", i, o_st_ready); end
            tick();
        end
        i_st_addr = 12'h044; i_commit = 1; #1;
        n_chk++; if (o_st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0b exp=0", o_st_ready); end
        tick();
        i_st_valid = 0; i_commit = 0; i_ld_valid = 1; i_ld_addr = 12'h050; i_ld_tag = 6'd9; #1;
        n_chk++; if (o_st_ready !== 1'b0 || o_ld_ready !== 1'b0) begin n_fail++;
            $display("FAIL full_block got st=%0b ld=%0b exp 0 0", o_st_ready, o_ld_ready); end
        n_chk++; if (o_we !== 1'b1 || o_addr !== 12'h040 || o_data !== 32'h4000) begin n_fail++;
            $display("FAIL full_drain got we=%0b addr=%h data=%h exp 1 040 4000", o_we, o_addr, o_data); end
        tick(); #1;
        n_chk++; if (o_ld_ready !== 1'b1 || o_we !== 1'b0 || o_addr !== 12'h050) begin n_fail++;
            $display("FAIL full_load got ready=%0b we=%0b addr=%h exp 1 0 050", o_ld_ready, o_we, o_addr); end
        tick();
        i_ld_valid = 0; #1;
        n_chk++; if (o_ld_valid !== 1'b1 || o_ld_tag !== 6'd9 || o_ld_data !== pat(12'h050)) begin n_fail++;
            $display("FAIL full_result got v=%0b tag=%0d data=%h exp 1 9 %h", o_ld_valid, o_ld_tag, o_ld_data, pat(12'h050)); end
        i_flush = 1;
        tick();
        i_flush = 0;
    endtask

    task automatic test_flush();
        i_st_valid = 1; i_st_addr = 12'h060; i_st_data = 32'hA0;
        tick();
        i_st_addr = 12'h061; i_st_data = 32'hA1; i_commit = 1;
        tick();
        i_st_addr = 12'h062; i_st_data = 32'hA2; i_ld_valid = 1; i_ld_addr = 12'h070; i_ld_tag = 6'd1; #1;
        n_chk++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL flush_ld_prio got we=%0b exp=0", o_we); end
        tick();
        i_st_addr = 12'h063; i_st_data = 32'hA3; i_commit = 0;
        tick();
        i_st_addr = 12'h064; i_st_data = 32'hA4; i_flush = 1; i_ld_valid = 0; #1;
        n_chk++; if (o_we !== 1'b1 || o_addr !== 12'h060 || o_data !== 32'hA0) begin n_fail++;
            $display("FAIL flush_drain0 got we=%0b addr=%h data=%h exp 1 060 a0", o_we, o_addr, o_data); end
        tick();
        i_st_valid = 0; i_flush = 0; #1;
        n_chk++; if (o_we !== 1'b1 || o_addr !== 12'h061 || o_data !== 32'hA1) begin n_fail++;
            $display("FAIL flush_drain1 got we=%0b addr=%h data=%h exp 1 061 a1", o_we, o_addr, o_data); end
        tick();
        i_commit = 1; #1;
        n_chk++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL flush_empty got we=%0b exp=0", o_we); end
        tick();
        i_commit = 0; i_ld_valid = 1; i_ld_addr = 12'h063; i_ld_tag = 6'd3; #1;
        n_chk++; if (o_st_ready !== 1'b1 || o_addr !== 12'h063) begin n_fail++;
            $display("FAIL flush_miss063 got st=%0b addr=%h exp 1 063", o_st_ready, o_addr); end
        tick();
        i_ld_addr = 12'h061; i_ld_tag = 6'd4; #1;
        n_chk++; if (o_ld_data !== pat(12'h063) || o_ld_tag !== 6'd3) begin n_fail++;
            $display("FAIL flush_dropped got data=%h tag=%0d exp %h 3", o_ld_data, o_ld_tag, pat(12'h063)); end
        tick();
        i_ld_valid = 0; #1;
        n_chk++; if (o_ld_data !== 32'hA1 || o_ld_tag !== 6'd4) begin n_fail++;
            $display("FAIL flush_ram061 got data=%h tag=%0d exp a1 4", o_ld_data, o_ld_tag); end
        tick();
    endtask

    task automatic test_miss();
        bd_we = 1; bd_addr = 12'h100; bd_data = 32'hCAFE0001;
        tick();
        bd_we = 0; i_ld_valid = 1; i_ld_addr = 12'h100; i_ld_tag = 6'h2A; #1;
        n_chk++; if (o_addr !== 12'h100 || o_we !== 1'b0 || o_ld_ready !== 1'b1) begin n_fail++;
            $display("FAIL miss_addr got addr=%h we=%0b ready=%0b exp 100 0 1", o_addr, o_we, o_ld_ready); end
        tick();
        i_ld_valid = 0; #1;
        n_chk++; if (o_ld_valid !== 1'b1 || o_ld_data !== 32'hCAFE0001 || o_ld_tag !== 6'h2A) begin n_fail++;
            $display("FAIL miss_data got v=%0b data=%h tag=%h exp 1 cafe0001 2a", o_ld_valid, o_ld_data, o_ld_tag); end
        tick();
    endtask

    // Reference: a FIFO of stores with a committed prefix length, plus word memory for addresses 0..7.
    task automatic test_random();
        logic [11:0] q_addr [$];
        logic [31:0] q_data [$];
        logic [31:0] m_mem [8];
        int          m_ncmt, sz, sel;
        bit          e_pend, e_hit;
        logic [31:0] e_data, nd;
        logic [5:0]  e_tag;
        for (int a = 0; a < 8; a++) m_mem[a] = pat(12'(a));
        m_ncmt = 0; e_pend = 0; e_data = '0; e_tag = '0;
        idle_in(); rst_n = 0;
        tick(); rst_n = 1;
        tick();
        for (int c = 0; c < 600; c++) begin
            i_st_valid = ($urandom_range(0, 99) < 50);
            i_st_addr  = 12'($urandom_range(0, 7));
            i_st_data  = $urandom;
            i_commit   = ($urandom_range(0, 99) < 40);
            i_flush    = ($urandom_range(0, 99) < 5);
            i_ld_valid = ($urandom_range(0, 99) < 40);
            i_ld_addr  = 12'($urandom_range(0, 7));
            i_ld_tag   = 6'($urandom_range(0, 63));
            #1;
            sz = q_addr.size();
            if (sz == 4 && m_ncmt > 0) sel = 2;
            else if (i_ld_valid)       sel = 1;
            else if (m_ncmt > 0)       sel = 2;
            else                       sel = 0;
            e_hit = 0; nd = m_mem[i_ld_addr[2:0]];
            for (int j = sz - 1; j >= 0; j--)
                if (!e_hit && q_addr[j] == i_ld_addr) begin e_hit = 1; nd = q_data[j]; end
            n_chk++; if (o_st_ready !== (sz < 4) || o_ld_ready !== (sel == 1) || o_we !== (sel == 2)) begin n_fail++;
                $display("FAIL rnd_ctl c=%0d got st=%0b ld=%0b we=%0b exp %0b %0b %0b", c, o_st_ready, o_ld_ready, o_we, sz < 4, sel == 1, sel == 2); end
            if (sel == 2) begin
                n_chk++; if (o_addr !== q_addr[0] || o_data !== q_data[0]) begin n_fail++;
                    $display("FAIL rnd_drain c=%0d got addr=%h data=%h exp %h %h", c, o_addr, o_data, q_addr[0], q_data[0]); end
            end
            if (sel == 1 && !e_hit) begin
                n_chk++; if (o_addr !== i_ld_addr) begin n_fail++;
                    $display("FAIL rnd_ldaddr c=%0d got %h exp %h", c, o_addr, i_ld_addr); end
            end
            n_chk++; if (o_ld_valid !== e_pend || (e_pend && (o_ld_data !== e_data || o_ld_tag !== e_tag))) begin n_fail++;
                $display("FAIL rnd_resp c=%0d got v=%0b data=%h tag=%0d exp %0b %h %0d", c, o_ld_valid, o_ld_data, o_ld_tag, e_pend, e_data, e_tag); end
            e_pend = (sel == 1);
            if (sel == 1) begin e_data = nd; e_tag = i_ld_tag; end
            if (sel == 2) begin
                m_mem[q_addr[0][2:0]] = q_data[0];
                void'(q_addr.pop_front()); void'(q_data.pop_front());
                m_ncmt--;
            end
            if (i_commit && m_ncmt < q_addr.size()) m_ncmt++;
            if (i_flush) begin
                while (q_addr.size() > m_ncmt) begin void'(q_addr.pop_back()); void'(q_data.pop_back()); end
            end else if (i_st_valid && sz < 4) begin
                q_addr.push_back(i_st_addr); q_data.push_back(i_st_data);
            end
            tick();
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_drain();
        test_forward();
        test_full();
        test_flush();
        test_miss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
